// File: rtl/load_aligner.sv
// Load alignment unit: fetches one or two memory beats, moves the addressed bytes to bit 0 and extends them.
// Define LOAD_ALIGN_MISALIGNED_EN to build the two-beat path; without it a beat-crossing load returns res_fault.
`ifndef BIT_COUNT
`define BIT_COUNT 64
`endif

package HighLevelControl;
   typedef enum logic [2:0] {
      BYTE               = 3'd0,
      HALF_WORD          = 3'd1,
      WORD               = 3'd2,
      BYTE_UNSIGNED      = 3'd3,
      HALF_WORD_UNSIGNED = 3'd4,
      WORD_UNSIGNED      = 3'd5,
      NO_TRUNC           = 3'd6
   } truncSrc;
endpackage

module load_aligner
   import HighLevelControl::*;
#(
   parameter int BIT_COUNT = `BIT_COUNT,
   parameter int BUS_BYTES = BIT_COUNT / 8,
   parameter int OFF_W     = $clog2(BUS_BYTES)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [OFF_W-1:0]     req_offset,
   input  truncSrc              req_trunc,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic                 mem_req_hi,
   input  logic                 mem_rvalid,
   input  logic [BIT_COUNT-1:0] mem_rdata,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [BIT_COUNT-1:0] res_data,
   output logic                 res_fault
);

   localparam int SZ_W = OFF_W + 2;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ_LO, S_WAIT_LO, S_REQ_HI, S_WAIT_HI, S_DONE, S_DRAIN
   } state_t;

   state_t               state_q, state_d;
   logic [OFF_W-1:0]     off_q, off_d;
   truncSrc              trunc_q, trunc_d;
   logic                 span_q, span_d;
   logic [BIT_COUNT-1:0] res_data_q, res_data_d;
`ifdef LOAD_ALIGN_MISALIGNED_EN
   logic [BIT_COUNT-1:0] beat0_q, beat0_d;
`else
   logic                 fault_q, fault_d;
`endif

   function automatic logic [SZ_W-1:0] size_of(input truncSrc t);
      case (t)
         BYTE, BYTE_UNSIGNED:           return SZ_W'(1);
         HALF_WORD, HALF_WORD_UNSIGNED: return SZ_W'(2);
         WORD:                          return SZ_W'(4);
`ifdef BIT_COUNT_64
         WORD_UNSIGNED:                 return SZ_W'(4);
`endif
         NO_TRUNC:                      return SZ_W'(BUS_BYTES);
         default:                       return SZ_W'(1);
      endcase
   endfunction

   // Shift the beat pair down by the byte offset, keep the addressed bytes, then extend.
   function automatic logic [BIT_COUNT-1:0] extend(input logic [2*BIT_COUNT-1:0] pair,
                                                   input logic [OFF_W-1:0] off,
                                                   input truncSrc t);
      logic [BIT_COUNT-1:0] lo;
      logic signed [7:0]    b_s;
      logic signed [15:0]   h_s;
      logic signed [31:0]   w_s;
      lo  = BIT_COUNT'(pair >> {off, 3'b000});
      b_s = lo[7:0];
      h_s = lo[15:0];
      w_s = lo[31:0];
      case (t)
         BYTE:               return BIT_COUNT'(b_s);
         HALF_WORD:          return BIT_COUNT'(h_s);
         WORD:               return BIT_COUNT'(w_s);
         BYTE_UNSIGNED:      return BIT_COUNT'(lo[7:0]);
         HALF_WORD_UNSIGNED: return BIT_COUNT'(lo[15:0]);
`ifdef BIT_COUNT_64
         WORD_UNSIGNED:      return BIT_COUNT'(lo[31:0]);
`endif
         NO_TRUNC:           return lo;
         default:            return 'x;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      off_d      = off_q;
      trunc_d    = trunc_q;
      span_d     = span_q;
      res_data_d = res_data_q;
`ifdef LOAD_ALIGN_MISALIGNED_EN
      beat0_d    = beat0_q;
`else
      fault_d    = fault_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               off_d   = req_offset;
               trunc_d = req_trunc;
               span_d  = (SZ_W'(req_offset) + size_of(req_trunc)) > SZ_W'(BUS_BYTES);
               state_d = S_REQ_LO;
            end
         end
         S_REQ_LO: begin
            if (flush)              state_d = S_IDLE;
            else if (mem_req_ready) state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (flush) begin
               state_d = S_DRAIN;
            end else if (mem_rvalid) begin
`ifdef LOAD_ALIGN_MISALIGNED_EN
               beat0_d = mem_rdata;
               if (span_q) begin
                  state_d = S_REQ_HI;
               end else begin
                  res_data_d = extend({{BIT_COUNT{1'b0}}, mem_rdata}, off_q, trunc_q);
                  state_d    = S_DONE;
               end
`else
               fault_d    = span_q;
               res_data_d = span_q ? '0 : extend({{BIT_COUNT{1'b0}}, mem_rdata}, off_q, trunc_q);
               state_d    = S_DONE;
`endif
            end
         end
`ifdef LOAD_ALIGN_MISALIGNED_EN
         S_REQ_HI: begin
            if (flush)              state_d = S_IDLE;
            else if (mem_req_ready) state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (flush) begin
               state_d = S_DRAIN;
            end else if (mem_rvalid) begin
               res_data_d = extend({mem_rdata, beat0_q}, off_q, trunc_q);
               state_d    = S_DONE;
            end
         end
`endif
         S_DONE: begin
            if (flush || res_ready) begin
               state_d = S_IDLE;
`ifndef LOAD_ALIGN_MISALIGNED_EN
               fault_d = 1'b0;
`endif
            end
         end
         // A beat already requested will still arrive; swallow exactly one.
         S_DRAIN: begin
            if (mem_rvalid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         off_q      <= '0;
         trunc_q    <= BYTE;
         span_q     <= 1'b0;
         res_data_q <= '0;
`ifdef LOAD_ALIGN_MISALIGNED_EN
         beat0_q    <= '0;
`else
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         trunc_q    <= trunc_d;
         span_q     <= span_d;
         res_data_q <= res_data_d;
`ifdef LOAD_ALIGN_MISALIGNED_EN
         beat0_q    <= beat0_d;
`else
         fault_q    <= fault_d;
`endif
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign mem_req_valid = (state_q == S_REQ_LO) || (state_q == S_REQ_HI);
   assign mem_req_hi    = (state_q == S_REQ_HI);
   assign res_valid     = (state_q == S_DONE);
   assign res_data      = res_data_q;
`ifdef LOAD_ALIGN_MISALIGNED_EN
   assign res_fault     = 1'b0;
`else
   assign res_fault     = fault_q;
`endif

endmodule

// File: tb/tb_load_aligner.sv
// Randomised bench for load_aligner, checked against a byte-level model of the load rules.
`ifndef BIT_COUNT
`define BIT_COUNT 64
`define BIT_COUNT_64
`endif

module tb_load_aligner;
   import HighLevelControl::*;

   localparam int BC    = `BIT_COUNT;
   localparam int BB    = BC / 8;
   localparam int OFF_W = $clog2(BB);
`ifdef LOAD_ALIGN_MISALIGNED_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n, flush, req_valid, req_ready;
   logic [OFF_W-1:0] req_offset;
   truncSrc          req_trunc;
   logic             mem_req_valid, mem_req_ready, mem_req_hi, mem_rvalid;
   logic [BC-1:0]    mem_rdata, res_data;
   logic             res_valid, res_ready, res_fault;

   int      vectors = 0;
   int      errors  = 0;
   truncSrc legal[$];

   load_aligner dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_offset(req_offset), .req_trunc(req_trunc),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_hi(mem_req_hi),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_fault(res_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [BC-1:0] rand_beat();
      logic [BC-1:0] r;
      for (int i = 0; i < BC / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Byte-by-byte picture of a load: gather size bytes starting at off across the two beats, then fill.
   function automatic void model(input int off, input truncSrc t, input logic [BC-1:0] b0, b1,
                                 output logic [BC-1:0] d, output logic f, output int nf);
      int sz;
      bit sgn, sp;
      logic [7:0] by, top;
      sgn = (t == BYTE) || (t == HALF_WORD) || (t == WORD);
      case (t)
         BYTE, BYTE_UNSIGNED:           sz = 1;
         HALF_WORD, HALF_WORD_UNSIGNED: sz = 2;
         NO_TRUNC:                      sz = BB;
         default:                       sz = 4;
      endcase
      sp  = (off + sz) > BB;
      d   = '0;
      f   = 1'b0;
      nf  = 1;
      top = 8'h00;
      if (sp && !MIS) begin
         f = 1'b1;
         return;
      end
      if (sp) nf = 2;
      for (int i = 0; i < BB; i++) begin
         if (i < sz) begin
            by  = (off + i < BB) ? b0[(off+i)*8 +: 8] : b1[(off+i-BB)*8 +: 8];
            top = by;
         end else begin
            by = (sgn && top[7]) ? 8'hFF : 8'h00;
         end
         d[i*8 +: 8] = by;
      end
   endfunction

   // Issue one load from an IDLE cycle and play memory; returns at the cycle after the result handshake.
   task automatic run_load(input logic [OFF_W-1:0] off, input truncSrc t, input logic [BC-1:0] b0, b1,
                           input int rd, vd, hold, input bit stray,
                           output logic [BC-1:0] d, output logic f, output int lat, output int nf,
                           output logic [1:0] hiseq, output bit stable, output bit rr_done, output bit to);
      int phase, cnt;
      logic cur_hi;
      nf = 0; hiseq = 2'b00; stable = 1'b1; rr_done = 1'b0; to = 1'b1; lat = 0;
      d = '0; f = 1'b0; phase = 0; cnt = 0; cur_hi = 1'b0;
      req_valid = 1'b1; req_offset = off; req_trunc = t;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         mem_req_ready = 1'b0; mem_rvalid = 1'b0;
         if (res_valid === 1'b1) begin
            d = res_data; f = res_fault; lat = c; rr_done = req_ready; to = 1'b0;
            for (int k = 0; k < hold; k++) begin
               if (stray) begin mem_rvalid = 1'b1; mem_rdata = rand_beat(); end
               @(posedge clk); #1;
               mem_rvalid = 1'b0;
               if (res_valid !== 1'b1 || res_data !== d || res_fault !== f) stable = 1'b0;
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            break;
         end
         if (phase == 2) begin
            if (cnt == 0) begin
               mem_rvalid = 1'b1; mem_rdata = cur_hi ? b1 : b0; phase = 0;
            end else cnt--;
         end else begin
            if (phase == 0 && mem_req_valid === 1'b1) begin
               cur_hi = mem_req_hi;
               if (nf < 2) hiseq[nf] = cur_hi;
               nf++; phase = 1; cnt = rd;
            end
            if (phase == 1) begin
               if (cnt == 0) begin
                  mem_req_ready = 1'b1; phase = 2; cnt = vd;
               end else begin
                  cnt--;
                  if (stray) begin mem_rvalid = 1'b1; mem_rdata = rand_beat(); end
               end
            end
         end
         @(posedge clk); #1;
      end
      mem_req_ready = 1'b0; mem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vectors += 6;
      if (req_ready !== 1'b1)     begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
      if (mem_req_hi !== 1'b0)    begin errors++; $display("FAIL reset_mem_req_hi: got %b want 0", mem_req_hi); end
      if (res_valid !== 1'b0)     begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
      if (res_fault !== 1'b0)     begin errors++; $display("FAIL reset_res_fault: got %b want 0", res_fault); end
      if (res_data !== '0)        begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_plan_vectors();
      logic [BC-1:0] d, b0;
      logic f; int lat, nf; logic [1:0] hs; bit st, rr, to;
      b0 = BC'(64'h8877665544332211);
      run_load(3, BYTE, b0, '0, 0, 0, 0, 0, d, f, lat, nf, hs, st, rr, to);
      vectors += 3;
      if (d !== BC'(64'h44)) begin errors++; $display("FAIL plan_byte_off3: got %h want %h", d, BC'(64'h44)); end
      if (lat !== 3)         begin errors++; $display("FAIL plan_latency: got %0d want 3", lat); end
      if (f !== 1'b0)        begin errors++; $display("FAIL plan_fault: got %b want 0", f); end
      run_load(7, BYTE, b0, '0, 0, 0, 0, 0, d, f, lat, nf, hs, st, rr, to);
      vectors++;
      if (d !== BC'(64'hFFFFFFFFFFFFFF88)) begin errors++; $display("FAIL plan_byte_off7: got %h want %h", d, BC'(64'hFFFFFFFFFFFFFF88)); end
      run_load(7, BYTE_UNSIGNED, b0, '0, 0, 0, 0, 0, d, f, lat, nf, hs, st, rr, to);
      vectors++;
      if (d !== BC'(64'h88)) begin errors++; $display("FAIL plan_ubyte_off7: got %h want %h", d, BC'(64'h88)); end
   endtask

   task automatic test_span();
      logic [BC-1:0] d, ed;
      logic f, ef; int lat, nf, elat, enf; logic [1:0] hs, ehs; bit st, rr, to;
`ifdef LOAD_ALIGN_MISALIGNED_EN
      ed = BC'(64'h0000000000AA8877); ef = 1'b0; enf = 2; elat = 5; ehs = 2'b10;
`else
      ed = '0; ef = 1'b1; enf = 1; elat = 3; ehs = 2'b00;
`endif
      run_load(6, WORD, BC'(64'h8877665544332211), BC'(64'hAA), 0, 0, 2, 1, d, f, lat, nf, hs, st, rr, to);
      vectors += 7;
      if (d !== ed)     begin errors++; $display("FAIL span_data: got %h want %h", d, ed); end
      if (f !== ef)     begin errors++; $display("FAIL span_fault: got %b want %b", f, ef); end
      if (nf !== enf)   begin errors++; $display("FAIL span_fetches: got %0d want %0d", nf, enf); end
      if (hs !== ehs)   begin errors++; $display("FAIL span_hi_seq: got %b want %b", hs, ehs); end
      if (lat !== elat) begin errors++; $display("FAIL span_latency: got %0d want %0d", lat, elat); end
      if (st !== 1'b1)  begin errors++; $display("FAIL span_hold_stable: got %b want 1", st); end
      if (res_fault !== 1'b0) begin errors++; $display("FAIL span_fault_clear: got %b want 0", res_fault); end
   endtask

   task automatic test_hold();
      logic [BC-1:0] d, b0, ed;
      logic f, ef; int lat, nf, enf; logic [1:0] hs; bit st, rr, to;
      b0 = rand_beat();
      model(2, HALF_WORD, b0, '0, ed, ef, enf);
      run_load(2, HALF_WORD, b0, '0, 1, 1, 4, 1, d, f, lat, nf, hs, st, rr, to);
      vectors += 3;
      if (to !== 1'b0) begin errors++; $display("FAIL hold_timeout: got %b want 0", to); end
      if (st !== 1'b1) begin errors++; $display("FAIL hold_stable: got %b want 1", st); end
      if (d !== ed)    begin errors++; $display("FAIL hold_data: got %h want %h", d, ed); end
   endtask

   task automatic test_flush();
      logic [BC-1:0] d, b0, ed;
      logic f, ef; int lat, nf, enf; logic [1:0] hs; bit st, rr, to;
      req_valid = 1'b1; req_offset = 0; req_trunc = WORD;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_drain_busy1: got %b want 0", req_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      vectors += 2;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_drain_busy2: got %b want 0", req_ready); end
      if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_no_result: got %b want 0", res_valid); end
      mem_rvalid = 1'b1; mem_rdata = BC'(64'hDEADBEEFCAFEF00D);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      vectors += 2;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_after_stale: got %b want 1", req_ready); end
      if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_stale_dropped: got %b want 0", res_valid); end
      b0 = rand_beat();
      model(1, HALF_WORD_UNSIGNED, b0, '0, ed, ef, enf);
      run_load(1, HALF_WORD_UNSIGNED, b0, '0, 0, 0, 0, 0, d, f, lat, nf, hs, st, rr, to);
      vectors += 2;
      if (d !== ed)    begin errors++; $display("FAIL flush_next_data: got %h want %h", d, ed); end
      if (lat !== 3)   begin errors++; $display("FAIL flush_next_latency: got %0d want 3", lat); end
   endtask

   task automatic test_flush_other();
      logic [BC-1:0] b0, ed;
      logic ef; int enf;
      req_valid = 1'b1; req_offset = 0; req_trunc = BYTE;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b1;
      vectors++;
      if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL flush_reqlo_fetching: got %b want 1", mem_req_valid); end
      @(posedge clk); #1;
      flush = 1'b0;
      vectors += 2;
      if (req_ready !== 1'b1)     begin errors++; $display("FAIL flush_reqlo_idle: got %b want 1", req_ready); end
      if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_reqlo_stop: got %b want 0", mem_req_valid); end
      req_valid = 1'b1; req_offset = 0; req_trunc = BYTE;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = rand_beat();
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      vectors++;
      if (res_valid !== 1'b1) begin errors++; $display("FAIL flush_done_valid: got %b want 1", res_valid); end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      vectors += 2;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_done_drop: got %b want 0", res_valid); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_done_idle: got %b want 1", req_ready); end
      b0 = BC'(64'h0123456789ABCDEF);
      model(4, WORD, b0, '0, ed, ef, enf);
      flush = 1'b1; req_valid = 1'b1; req_offset = 4; req_trunc = WORD;
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      vectors += 2;
      if (req_ready !== 1'b0)     begin errors++; $display("FAIL flush_idle_accept: got %b want 0", req_ready); end
      if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL flush_idle_fetch: got %b want 1", mem_req_valid); end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = b0;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      vectors += 2;
      if (res_valid !== 1'b1) begin errors++; $display("FAIL flush_idle_result_valid: got %b want 1", res_valid); end
      if (res_data !== ed)    begin errors++; $display("FAIL flush_idle_result_data: got %h want %h", res_data, ed); end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset_midflight();
      logic hi_seen;
      hi_seen = 1'b0;
      req_valid = 1'b1; req_offset = 6; req_trunc = WORD;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
`ifdef LOAD_ALIGN_MISALIGNED_EN
      mem_rvalid = 1'b1; mem_rdata = rand_beat();
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_req_ready = 1'b1; hi_seen = mem_req_hi;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      vectors++;
      if (hi_seen !== 1'b1) begin errors++; $display("FAIL midreset_hi_fetch: got %b want 1", hi_seen); end
`endif
      #2 reset_n = 1'b0;
      #1;
      vectors += 6;
      if (req_ready !== 1'b1)     begin errors++; $display("FAIL midreset_req_ready: got %b want 1", req_ready); end
      if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL midreset_mem_req_valid: got %b want 0", mem_req_valid); end
      if (mem_req_hi !== 1'b0)    begin errors++; $display("FAIL midreset_mem_req_hi: got %b want 0", mem_req_hi); end
      if (res_valid !== 1'b0)     begin errors++; $display("FAIL midreset_res_valid: got %b want 0", res_valid); end
      if (res_fault !== 1'b0)     begin errors++; $display("FAIL midreset_res_fault: got %b want 0", res_fault); end
      if (res_data !== '0)        begin errors++; $display("FAIL midreset_res_data: got %h want 0", res_data); end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [BC-1:0] d, b0, b1, ed;
      logic f, ef; int lat, nf, enf; logic [1:0] hs; bit st, rr, to;
      truncSrc t; int off;
      for (int n = 0; n < 4; n++) begin
         b0 = rand_beat(); b1 = rand_beat();
         t = legal[$urandom_range(0, legal.size() - 1)];
         off = $urandom_range(0, BB - 1);
         model(off, t, b0, b1, ed, ef, enf);
         run_load(OFF_W'(off), t, b0, b1, 0, 0, 0, 0, d, f, lat, nf, hs, st, rr, to);
         vectors += 3;
         if (d !== ed)           begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", n, d, ed); end
         if (rr !== 1'b0)        begin errors++; $display("FAIL b2b_busy_in_done[%0d]: got %b want 0", n, rr); end
         if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after[%0d]: got %b want 1", n, req_ready); end
      end
   endtask

   task automatic test_random();
      logic [BC-1:0] d, b0, b1, ed;
      logic f, ef; int lat, nf, enf, elat, rd, vd, off; logic [1:0] hs, ehs; bit st, rr, to;
      truncSrc t;
      for (int n = 0; n < 40; n++) begin
         b0 = rand_beat(); b1 = rand_beat();
         t = legal[$urandom_range(0, legal.size() - 1)];
         off = $urandom_range(0, BB - 1);
         rd = $urandom_range(0, 2); vd = $urandom_range(0, 2);
         model(off, t, b0, b1, ed, ef, enf);
         elat = (enf == 2) ? 5 + 2 * (rd + vd) : 3 + rd + vd;
         ehs  = (enf == 2) ? 2'b10 : 2'b00;
         run_load(OFF_W'(off), t, b0, b1, rd, vd, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                  d, f, lat, nf, hs, st, rr, to);
         vectors += 6;
         if (d !== ed)     begin errors++; $display("FAIL rand_data[%0d] off=%0d t=%0d: got %h want %h", n, off, t, d, ed); end
         if (f !== ef)     begin errors++; $display("FAIL rand_fault[%0d]: got %b want %b", n, f, ef); end
         if (lat !== elat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, elat); end
         if (nf !== enf)   begin errors++; $display("FAIL rand_fetches[%0d]: got %0d want %0d", n, nf, enf); end
         if (hs !== ehs)   begin errors++; $display("FAIL rand_hi_seq[%0d]: got %b want %b", n, hs, ehs); end
         if (st !== 1'b1)  begin errors++; $display("FAIL rand_stable[%0d]: got %b want 1", n, st); end
      end
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_offset = '0; req_trunc = BYTE;
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; res_ready = 1'b0;
      legal = '{BYTE, HALF_WORD, WORD, BYTE_UNSIGNED, HALF_WORD_UNSIGNED, NO_TRUNC};
`ifdef BIT_COUNT_64
      legal.push_back(WORD_UNSIGNED);
`endif
      test_reset();
      test_plan_vectors();
      test_span();
      test_hold();
      test_flush();
      test_flush_other();
      test_reset_midflight();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
